expr_dp_sequencer: RTL and testbench
====================================

Name: expr_dp_sequencer

Overview:
- Sequences access to one shared combinational expression datapath (60-bit packed operand group in, 90-bit packed result y out) on behalf of two requesters.
- Round-robin arbitrates requests and registers the winning operand vector onto the datapath inputs. Holds the inputs for a programmable settle time, then captures y and returns it with the requester ID.
- Keeps a rotate-XOR signature and a transaction count for regression self-checking.

Parameters:
- SETTLE_CYCLES, 2, cycles operands are held before y is captured (legal range 1..15)
- CNT_W, 16, width of the transaction counter

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operand vector
- req0_ready  out  1  requester 0 accepted this cycle
- req0_opnd  in  60  packed {a0[3:0],a1[4:0],a2[5:0],a3[3:0],a4[4:0],a5[5:0],b0,b1,b2,b3,b4,b5} (same widths for b)
- req1_valid  in  1  requester 1 has an operand vector
- req1_ready  out  1  requester 1 accepted this cycle
- req1_opnd  in  60  same packing as req0_opnd
- dp_opnd  out  60  registered operands driven to the shared datapath
- dp_y  in  90  datapath result, combinational from dp_opnd
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  requester that owns rsp_y
- rsp_y  out  90  captured result
- sig  out  90  running result signature
- txn_count  out  CNT_W  completed responses, wraps
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE, dp_opnd=0, rsp_valid=0, rsp_id=0, rsp_y=0, sig=0, txn_count=0, settle counter=0, last_grant=1 (req0 wins the first tie). Reset mid-transaction drops that transaction silently.
- Clock and reset are the only timing inputs. No other asynchronous paths exist.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - grant = req0 if only req0_valid; req1 if only req1_valid; if both, the requester != last_grant.
  - reqN_ready = (state==IDLE) && grant==N && reqN_valid. This is combinational; at most one ready is high per cycle.
  - On accept edge E0: dp_opnd<=granted opnd, rsp_id<=grant, last_grant<=grant, cnt<=SETTLE_CYCLES-1, state<=SETTLE.
- SETTLE:
  - dp_opnd held stable. Each cycle, if cnt!=0 then cnt--.
  - When cnt==0, capture on that edge: rsp_y<=dp_y, rsp_valid<=1, state<=RESP.
  - Capture therefore happens at edge E0+SETTLE_CYCLES, and rsp_valid is first high in the cycle after it. Accept-to-rsp_valid latency = SETTLE_CYCLES cycles.
- RESP:
  - rsp_valid, rsp_id and rsp_y are held until rsp_valid && rsp_ready.
  - On that edge: rsp_valid<=0, sig<={sig[88:0],sig[89]} ^ rsp_y, txn_count<=txn_count+1 (modulo 2^CNT_W), state<=IDLE.
  - No request is accepted in RESP. A request may be accepted in the IDLE cycle immediately following.
  - Peak throughput: one transaction per SETTLE_CYCLES+2 cycles.
- dp_opnd is not cleared after a transaction; it keeps the last operands until the next accept.
- Requester inputs are sampled only on the accept edge. Changes to reqN_opnd outside that edge have no effect.
- Requesters must hold valid/opnd until ready. The block does not check for this.
- rsp_ready high while not in RESP is ignored.
- rsp_ready held permanently high: the response still lasts exactly one cycle.
- txn_count wraps from 2^CNT_W-1 to 0 with no flag.
- Both requests are persistently valid: grants strictly alternate 0,1,0,1...

Test Plan:
- Reset then req0_valid=1, opnd=60'h0123456789ABCDE, SETTLE_CYCLES=2, stub dp_y=opnd zero-extended, rsp_ready=1 -> req0_ready high in cycle 1; rsp_valid high exactly 2 cycles after accept with rsp_id=0, rsp_y=90'h0123456789ABCDE; txn_count=1; sig=90'h0123456789ABCDE.
- Both requesters valid continuously for 6 transactions -> grant order 0,1,0,1,0,1; never both ready in one cycle; txn_count=6.
- rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_y and rsp_id stable; both reqN_ready=0; busy=1; after rsp_ready=1, exactly one handshake.
- Change dp_y stub output during SETTLE (value changes on the cycle before capture) -> rsp_y equals dp_y at the capture edge E0+SETTLE_CYCLES.
- Assert rst during SETTLE -> all outputs return to reset values immediately (asynchronously); the next req1 request completes normally with rsp_id=1; sig excludes the aborted transaction.
- Two responses y=90'h1 then y=90'h1 -> sig goes 90'h1 then 90'h3 (rotate-XOR). Drive CNT_W=4 through 16 transactions -> txn_count wraps to 0.

Source files
------------

// File: rtl/expr_dp_sequencer.sv
// Round-robin sequencer for one shared combinational expression datapath.
// Registers the winning operands, waits SETTLE_CYCLES, captures y, and keeps a signature and count.
module expr_dp_sequencer #(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [59:0]      req0_opnd,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [59:0]      req1_opnd,
   output logic [59:0]      dp_opnd,
   input  logic [89:0]      dp_y,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [89:0]      rsp_y,
   output logic [89:0]      sig,
   output logic [CNT_W-1:0] txn_count,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

   state_t     state, state_n;
   logic [3:0] cnt;
   logic       last_grant;
   logic       grant;
   logic       accept, capture, retire;

   // Tie goes to whoever did not win last; a lone requester always wins.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) grant = ~last_grant;
      else if (req1_valid)          grant = 1'b1;
   end

   always_comb begin
      state_n = state;
      accept  = 1'b0;
      capture = 1'b0;
      retire  = 1'b0;
      case (state)
         IDLE: if (req0_valid || req1_valid) begin
            accept  = 1'b1;
            state_n = SETTLE;
         end
         SETTLE: if (cnt == 4'd0) begin
            capture = 1'b1;
            state_n = RESP;
         end
         RESP: if (rsp_ready) begin
            retire  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign req0_ready = (state == IDLE) && !grant && req0_valid;
   assign req1_ready = (state == IDLE) &&  grant && req1_valid;
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dp_opnd    <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_y      <= '0;
         sig        <= '0;
         txn_count  <= '0;
         cnt        <= 4'd0;
         last_grant <= 1'b1;
      end else begin
         if (accept) begin
            dp_opnd    <= grant ? req1_opnd : req0_opnd;
            rsp_id     <= grant;
            last_grant <= grant;
            cnt        <= 4'(SETTLE_CYCLES - 1);
         end
         if (state == SETTLE && cnt != 4'd0) cnt <= cnt - 4'd1;
         if (capture) begin
            rsp_y     <= dp_y;
            rsp_valid <= 1'b1;
         end
         if (retire) begin
            rsp_valid <= 1'b0;
            sig       <= {sig[88:0], sig[89]} ^ rsp_y;
            txn_count <= txn_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_expr_dp_sequencer.sv
// Directed bench for expr_dp_sequencer: arbitration, latency, stall, reset abort, signature, count wrap.
module tb_expr_dp_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [59:0] req0_opnd, req1_opnd, dp_opnd;
   logic [89:0] dp_y, rsp_y, sig;
   logic        rsp_valid, rsp_ready, rsp_id, busy;
   logic [3:0]  txn_count;

   logic        ovr;
   logic [89:0] ovr_y;
   logic [89:0] sig_m;
   int          cnt_m;
   int          nvec = 0;
   int          nerr = 0;

   always #5 clk = ~clk;

   // Datapath stub: operands zero-extended unless a test forces a value.
   assign dp_y = ovr ? ovr_y : {30'b0, dp_opnd};

   expr_dp_sequencer #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opnd(req0_opnd),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opnd(req1_opnd),
      .dp_opnd(dp_opnd), .dp_y(dp_y),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
      .sig(sig), .txn_count(txn_count), .busy(busy)
   );

   task automatic chk(input string tag, input logic [89:0] obs, input logic [89:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      sig_m = '0;
      cnt_m = 0;
   endtask

   // Starts just after a posedge; returns just after the accept edge.
   task automatic accept(input int id, input logic [59:0] op);
      bit found = 0;
      if (id == 0) begin req0_valid = 1'b1; req0_opnd = op; end
      else         begin req1_valid = 1'b1; req1_opnd = op; end
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if ((id == 0) ? req0_ready : req1_ready) begin found = 1; break; end
      end
      chk("ready", 90'(found), 90'd1);
      chk("other_ready", 90'((id == 0) ? req1_ready : req0_ready), 90'd0);
      @(posedge clk);
      #1;
      if (id == 0) req0_valid = 1'b0;
      else         req1_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!rsp_valid && lat < 20);
   endtask

   // Called at a negedge with rsp_valid high and rsp_ready high.
   task automatic retire(input logic [89:0] yexp, input int id);
      chk("rsp_id", 90'(rsp_id), 90'(id));
      chk("rsp_y", rsp_y, yexp);
      @(posedge clk);
      #1;
      sig_m = {sig_m[88:0], sig_m[89]} ^ yexp;
      cnt_m = (cnt_m + 1) % 16;
      chk("rsp_drop", 90'(rsp_valid), 90'd0);
      chk("sig", sig, sig_m);
      chk("txn_count", 90'(txn_count), 90'(cnt_m));
   endtask

   task automatic run_txn(input int id, input logic [59:0] op);
      int lat;
      accept(id, op);
      wait_rsp(lat);
      chk("latency", 90'(lat), 90'd2);
      retire({30'b0, op}, id);
   endtask

   initial begin
      int lat, g, exp_g;
      logic [59:0] op0, op1;
      req0_valid = 0; req1_valid = 0; req0_opnd = '0; req1_opnd = '0;
      rsp_ready = 1; ovr = 0; ovr_y = '0;
      do_reset();

      // Reset state
      @(negedge clk);
      chk("rst_busy", 90'(busy), 90'd0);
      chk("rst_rsp_valid", 90'(rsp_valid), 90'd0);
      chk("rst_dp_opnd", 90'(dp_opnd), 90'd0);
      chk("rst_sig", sig, 90'd0);
      chk("rst_txn", 90'(txn_count), 90'd0);
      @(posedge clk); #1;

      // Single req0 transaction
      run_txn(0, 60'h0123456789ABCDE);
      chk("first_sig", sig, 90'h0123456789ABCDE);

      // Both requesters persistently valid: strict alternation from 0
      do_reset();
      op0 = 60'hA5A5_0000_1111_222; op1 = 60'h5A5A_3333_4444_555;
      req0_opnd = op0; req1_opnd = op1;
      req0_valid = 1; req1_valid = 1;
      exp_g = 0;
      for (int t = 0; t < 6; t++) begin
         bit found = 0;
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin found = 1; break; end
         end
         chk("alt_ready", 90'(found), 90'd1);
         chk("one_ready", 90'(req0_ready & req1_ready), 90'd0);
         g = req1_ready ? 1 : 0;
         chk("grant_order", 90'(g), 90'(exp_g));
         @(posedge clk); #1;
         wait_rsp(lat);
         chk("alt_latency", 90'(lat), 90'd2);
         retire(exp_g ? {30'b0, op1} : {30'b0, op0}, exp_g);
         exp_g ^= 1;
      end
      req0_valid = 0; req1_valid = 0;
      chk("six_txn", 90'(txn_count), 90'd6);

      // Back-pressure in RESP for 10 cycles
      rsp_ready = 0;
      accept(1, 60'hFEED_BEEF_CAFE_123);
      wait_rsp(lat);
      req0_valid = 1; req0_opnd = 60'h777;
      for (int c = 0; c < 10; c++) begin
         chk("stall_valid", 90'(rsp_valid), 90'd1);
         chk("stall_id", 90'(rsp_id), 90'd1);
         chk("stall_y", rsp_y, {30'b0, 60'hFEED_BEEF_CAFE_123});
         chk("stall_rdy", 90'({req0_ready, req1_ready}), 90'd0);
         chk("stall_busy", 90'(busy), 90'd1);
         @(posedge clk); @(negedge clk);
      end
      rsp_ready = 1;
      retire({30'b0, 60'hFEED_BEEF_CAFE_123}, 1);
      req0_valid = 0;
      @(posedge clk); #1;
      chk("one_handshake", 90'(txn_count), 90'(cnt_m));

      // dp_y changes during SETTLE; capture must take the value at the capture edge
      accept(0, 60'h1234);
      ovr = 1; ovr_y = 90'h3_0000_0000_0000_0000_AAAA;
      @(posedge clk); #1;
      ovr_y = 90'h2_FFFF_0000_FFFF_0000_5555;
      @(negedge clk);
      chk("pre_capture", 90'(rsp_valid), 90'd0);
      @(posedge clk); #1;
      ovr_y = 90'h1_1111_1111_1111_1111_1111;
      @(negedge clk);
      chk("capture_valid", 90'(rsp_valid), 90'd1);
      retire(90'h2_FFFF_0000_FFFF_0000_5555, 0);
      ovr = 0;

      // Async reset in SETTLE drops the transaction
      accept(0, 60'hDEAD);
      #3 rst = 1;
      #1;
      chk("arst_busy", 90'(busy), 90'd0);
      chk("arst_dp_opnd", 90'(dp_opnd), 90'd0);
      chk("arst_rsp_valid", 90'(rsp_valid), 90'd0);
      chk("arst_sig", sig, 90'd0);
      chk("arst_txn", 90'(txn_count), 90'd0);
      @(posedge clk); #1 rst = 0;
      sig_m = '0; cnt_m = 0;
      run_txn(1, 60'hBEEF_0042);
      chk("post_rst_sig", sig, 90'hBEEF_0042);

      // Rotate-XOR signature and 4-bit count wrap
      do_reset();
      run_txn(0, 60'h1);
      chk("sig_1", sig, 90'h1);
      run_txn(1, 60'h1);
      chk("sig_3", sig, 90'h3);
      for (int i = 0; i < 14; i++) run_txn(i % 2, 60'(i * 37 + 5));
      chk("count_wrap", 90'(txn_count), 90'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
